// File: rtl/conv_result_reader_if.sv
// -----------------------------------------------------------------------------
// conv_result_reader_if
// Bus bundle between the convolution result reader, its three filter-result
// banks and the downstream stream consumer.
//   rd_addr0/1/2  : read addresses to banks 0/1/2 (always equal)
//   rd_data0/1/2  : registered bank read data, valid one cycle after address
//   out_data0/1/2 : streamed filter results, one per bank
//   out_valid     : out_data*/out_last valid
//   out_ready     : consumer accepts; transfer when out_valid & out_ready
//   out_last      : current beat carries the final address
// master = reader side, slave = bank/consumer side.
// -----------------------------------------------------------------------------
interface conv_result_reader_if #(
    parameter int RESULT_WIDTH = 22,
    parameter int ADDR_WIDTH   = 18
);
    logic [ADDR_WIDTH-1:0]   rd_addr0, rd_addr1, rd_addr2;
    logic [RESULT_WIDTH-1:0] rd_data0, rd_data1, rd_data2;
    logic [RESULT_WIDTH-1:0] out_data0, out_data1, out_data2;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        output rd_addr0, rd_addr1, rd_addr2,
        input  rd_data0, rd_data1, rd_data2,
        output out_data0, out_data1, out_data2,
        output out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_addr0, rd_addr1, rd_addr2,
        output rd_data0, rd_data1, rd_data2,
        input  out_data0, out_data1, out_data2,
        input  out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/conv_result_reader.sv
// -----------------------------------------------------------------------------
// conv_result_reader
// Drains OUTPUT_SIZE results from three filter banks in lockstep and streams
// them out through a 2-entry FIFO with valid/ready flow control.
//   clk   : clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   start : begin a full drain (only looked at in IDLE)
//   busy  : high whenever the FSM is not IDLE
//   done  : one-cycle pulse after the final transfer
//   bus   : read/stream bundle (see conv_result_reader_if)
// -----------------------------------------------------------------------------
module conv_result_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH+6,
    parameter int OUTPUT_SIZE  = 222*222,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    conv_result_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUTPUT_SIZE - 1);

    state_t                       r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]        r_addr_next;   // next address to issue
    logic [ADDR_WIDTH-1:0]        r_addr_last;   // last address issued
    logic                         r_inflight;    // a read was issued last cycle
    logic                         r_inflight_last;
    logic [1:0]                   r_fifo_last;
    logic                         r_wr_ptr, r_rd_ptr;
    logic [1:0]                   r_count;
    logic                         r_done;

    logic [2:0][RESULT_WIDTH-1:0] w_rd_data;
    logic [2:0][RESULT_WIDTH-1:0] w_head;
    logic                         w_valid, w_pop, w_head_last;
    logic                         w_issue, w_issue_last;
    logic [2:0]                   w_pending;
    logic [ADDR_WIDTH-1:0]        w_rd_addr;

    assign w_rd_data[0] = bus.rd_data0;
    assign w_rd_data[1] = bus.rd_data1;
    assign w_rd_data[2] = bus.rd_data2;

    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid & bus.out_ready;
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // Slots that will be committed after this edge: held entries plus the
    // read landing now, minus the beat leaving now. A new read is allowed
    // only while that total leaves room for it, so the FIFO can never overflow.
    assign w_pending    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == READ) && (w_pending < 3'd2);
    assign w_issue_last = w_issue && (r_addr_next == LAST_ADDR);

    // The address shown is the one being issued this cycle; otherwise the
    // previous one is held so the banks see a stable address while stalled.
    assign w_rd_addr = w_issue            ? r_addr_next :
                       (r_state == IDLE)  ? '0          : r_addr_last;

    assign bus.rd_addr0 = w_rd_addr;
    assign bus.rd_addr1 = w_rd_addr;
    assign bus.rd_addr2 = w_rd_addr;

    // Per-channel FIFO storage; written only on the edge after an issued read.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic [RESULT_WIDTH-1:0] r_mem [0:1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                end else if (r_inflight) begin
                    r_mem[r_wr_ptr] <= w_rd_data[gi];
                end
            end
            assign w_head[gi] = r_mem[r_rd_ptr];
        end
    endgenerate

    assign bus.out_data0 = w_head[0];
    assign bus.out_data1 = w_head[1];
    assign bus.out_data2 = w_head[2];
    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_valid & w_head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr_next     <= '0;
            r_addr_last     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= 2'b00;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_done          <= (r_state == DRAIN) && w_pop && w_head_last;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (r_state == IDLE) begin
                r_addr_next <= '0;
                r_addr_last <= '0;
            end else if (w_issue) begin
                r_addr_last <= r_addr_next;
                r_addr_next <= r_addr_next + 1'b1;
            end
            if (r_inflight) begin
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = r_done;
        case (r_state)
            IDLE:    if (start)                 w_state_next = READ;
            READ:    if (w_issue_last)          w_state_next = DRAIN;
            DRAIN:   if (w_pop && w_head_last)  w_state_next = IDLE;
            default:                            w_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_result_reader.sv
// -----------------------------------------------------------------------------
// tb_conv_result_reader
// Directed bench for conv_result_reader with OUTPUT_SIZE=16. Bank k returns
// 100*k + address one cycle after the address (registered read).
// -----------------------------------------------------------------------------
module tb_conv_result_reader;
    localparam int DW = 8;
    localparam int RW = 2*DW+6;
    localparam int OS = 16;
    localparam int AW = 18;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    conv_result_reader_if #(.RESULT_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    conv_result_reader #(
        .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .OUTPUT_SIZE(OS), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read bank model.
    always @(posedge clk) begin
        bus.rd_data0 <= RW'(bus.rd_addr0);
        bus.rd_data1 <= RW'(100 + int'(bus.rd_addr1));
        bus.rd_data2 <= RW'(200 + int'(bus.rd_addr2));
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_seq   = 0;
    int idx     = 0;
    int t_first = 0;
    int t_last  = 0;
    int ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // out_ready driver, changes #1 after the rising edge.
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
            ph++;
        end
    end

    // Stream monitor: in-order data, last flag, stability while stalled,
    // and done exactly one cycle after the final transfer.
    logic           prev_stall = 1'b0;
    logic           prev_last_xfer = 1'b0;
    logic [RW-1:0]  prev_d0 = '0;
    logic           prev_l = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            idx            = 0;
            prev_stall     = 1'b0;
            prev_last_xfer = 1'b0;
        end else begin
            check_value("done_pulse", 32'(done), 32'(prev_last_xfer));
            if (done) n_seq++;
            if (prev_stall) begin
                check_value("stall_valid", 32'(bus.out_valid), 32'd1);
                check_value("stall_data0", 32'(bus.out_data0), 32'(prev_d0));
                check_value("stall_last",  32'(bus.out_last),  32'(prev_l));
            end
            prev_last_xfer = 1'b0;
            prev_stall     = bus.out_valid && !bus.out_ready;
            prev_d0        = bus.out_data0;
            prev_l         = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                $display("[TB] beat %0d: d0=%0d d1=%0d d2=%0d last=%0d", idx,
                         bus.out_data0, bus.out_data1, bus.out_data2, bus.out_last);
                check_value("beat_data0", 32'(bus.out_data0), 32'(idx));
                check_value("beat_data1", 32'(bus.out_data1), 32'(100 + idx));
                check_value("beat_data2", 32'(bus.out_data2), 32'(200 + idx));
                check_value("beat_last",  32'(bus.out_last),  32'(idx == OS-1));
                if (idx == 0)    t_first = cyc;
                if (idx == OS-1) t_last  = cyc;
                prev_last_xfer = (idx == OS-1);
                idx = (idx == OS-1) ? 0 : idx + 1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_seq(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_seq >= target) break;
        end
        check_value("seq_complete", 32'(n_seq), 32'(target));
    endtask

    initial begin
        int seq0;
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        // Reset state
        check_value("rst_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_last",  32'(bus.out_last),  32'd0);
        check_value("rst_data0", 32'(bus.out_data0), 32'd0);
        check_value("rst_addr",  32'(bus.rd_addr0),  32'd0);
        check_value("rst_busy",  32'(busy),          32'd0);
        check_value("rst_done",  32'(done),          32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: full-rate drain with latency checks
        pulse_start();                        // returns #1 after the start edge
        check_value("t1_busy",   32'(busy),          32'd1);
        check_value("t1_addr_a", 32'(bus.rd_addr0),  32'd0);
        check_value("t1_val_a",  32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check_value("t1_val_b",  32'(bus.out_valid), 32'd0);
        check_value("t1_addr_b", 32'(bus.rd_addr0),  32'd1);
        @(posedge clk); #1;
        check_value("t1_val_c",  32'(bus.out_valid), 32'd1);
        check_value("t1_data_c", 32'(bus.out_data0), 32'd0);
        check_value("t1_addr_c", 32'(bus.rd_addr0),  32'd2);
        wait_seq(1, 100);
        check_value("t1_burst", 32'(t_last - t_first), 32'(OS-1));
        @(negedge clk);
        check_value("t1_busy_after", 32'(busy), 32'd0);

        // 2: ready pattern 1,0,0,1
        ready_mode = 1;
        pulse_start();
        wait_seq(2, 200);
        ready_mode = 0;

        // 3: consumer stalls for 20 cycles
        ready_mode = 2;
        repeat (2) @(posedge clk);
        pulse_start();
        repeat (20) @(negedge clk);
        check_value("t3_valid", 32'(bus.out_valid), 32'd1);
        check_value("t3_addr",  32'(bus.rd_addr0),  32'd1);
        check_value("t3_data0", 32'(bus.out_data0), 32'd0);
        check_value("t3_data1", 32'(bus.out_data1), 32'd100);
        ready_mode = 0;
        wait_seq(3, 100);

        // 4: reset during beat 7
        seq0 = n_seq;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data0 == RW'(7)) break;
        end
        check_value("t4_reach_beat7", 32'(bus.out_data0), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check_value("t4_valid", 32'(bus.out_valid), 32'd0);
        check_value("t4_last",  32'(bus.out_last),  32'd0);
        check_value("t4_data0", 32'(bus.out_data0), 32'd0);
        check_value("t4_data2", 32'(bus.out_data2), 32'd0);
        check_value("t4_addr",  32'(bus.rd_addr0),  32'd0);
        check_value("t4_busy",  32'(busy),          32'd0);
        check_value("t4_done",  32'(done),          32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_value("t4_no_done", 32'(n_seq), 32'(seq0));
        check_value("t4_idle",    32'(busy),  32'd0);
        pulse_start();
        wait_seq(seq0 + 1, 100);

        // 5a: start re-asserted while busy is ignored
        seq0 = n_seq;
        pulse_start();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_seq(seq0 + 1, 100);
        repeat (30) @(negedge clk);
        check_value("t5_one_seq", 32'(n_seq), 32'(seq0 + 1));
        check_value("t5_idle",    32'(busy),  32'd0);

        // 5b: start during the done cycle launches a second drain
        seq0 = n_seq;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check_value("t5_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_value("t5_restart_busy", 32'(busy), 32'd1);
        wait_seq(seq0 + 2, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
